instr_fetch: RTL and testbench

- Fetch stage of the single-cycle RISC-V core; sits directly upstream of `control_unit`.
- Owns the PC and talks to instruction memory over a req/ack handshake that tolerates variable latency.
- Holds the current instruction in an instruction register (IR) and prefetches the next one into a one-entry buffer (PB).
- Presents `op`/`funct3`/`funct7` to the control unit and applies the PCSrc redirect when the core retires an instruction.

---
 rtl/rv_fetch_pkg.sv | 24 ++
 rtl/instr_fetch.sv | 127 ++++++++++++
 tb/tb_instr_fetch.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared fetch-stage definitions: FSM states, NOP encoding, reset PC and
// instruction field positions (also used by control_unit).
package rv_fetch_pkg;

    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0]     RESET_PC_DEF = 32'h0000_0000;

    // Base-ISA field positions
    localparam int unsigned OP_LSB     = 0;
    localparam int unsigned OP_W       = 7;
    localparam int unsigned FUNCT3_LSB = 12;
    localparam int unsigned FUNCT3_W   = 3;
    localparam int unsigned FUNCT7_LSB = 25;
    localparam int unsigned FUNCT7_W   = 7;

    typedef enum logic [1:0] {
        FETCH      = 2'd0,
        FULL_FETCH = 2'd1,
        FULL_HOLD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, fetches over a variable-latency req/ack port,
// holds the current instruction (IR) plus a one-word prefetch buffer (PB).
module instr_fetch
    import rv_fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_ack,
    input  logic [ILEN-1:0]     imem_rdata,
    output logic                instr_valid,
    output logic [ILEN-1:0]     instr,
    output logic [XLEN-1:0]     pc,
    output logic [XLEN-1:0]     pc_plus4,
    output logic [OP_W-1:0]     op,
    output logic [FUNCT3_W-1:0] funct3,
    output logic [FUNCT7_W-1:0] funct7,
    input  logic                consume,
    input  logic                redirect,
    input  logic [XLEN-1:0]     redirect_target,
    output logic                misalign_err
);

    fetch_state_e    state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] pend_pc;
    logic [XLEN-1:0] pb_pc;
    logic [ILEN-1:0] pb;
    logic            drop;

    logic            ack_v;
    logic            take;
    logic            redir;
    logic [XLEN-1:0] target;

    assign ack_v  = imem_req & imem_ack;
    assign take   = consume & instr_valid;
    assign redir  = take & redirect;
    assign target = {redirect_target[XLEN-1:2], 2'b00};

    assign imem_addr = fetch_pc;
    assign pc_plus4  = pc + XLEN'(4);
    assign op        = instr[OP_LSB     +: OP_W];
    assign funct3    = instr[FUNCT3_LSB +: FUNCT3_W];
    assign funct7    = instr[FUNCT7_LSB +: FUNCT7_W];

    // Fetch FSM; a redirect with an unacked request parks the target in
    // pend_pc so imem_addr stays stable until the stale ack is discarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= FETCH;
            imem_req     <= 1'b0;
            fetch_pc     <= RESET_PC;
            pend_pc      <= RESET_PC;
            instr_valid  <= 1'b0;
            instr        <= NOP_INSTR;
            pc           <= RESET_PC;
            pb           <= NOP_INSTR;
            pb_pc        <= RESET_PC;
            drop         <= 1'b0;
            misalign_err <= 1'b0;
        end else if (drop) begin
            if (ack_v) begin
                drop     <= 1'b0;
                fetch_pc <= pend_pc;
            end
        end else if (redir) begin
            instr_valid <= 1'b0;
            state       <= FETCH;
            imem_req    <= 1'b1;
            if (redirect_target[1:0] != 2'b00) begin
                misalign_err <= 1'b1;
            end
            if (imem_req && !ack_v) begin
                drop    <= 1'b1;
                pend_pc <= target;
            end else begin
                fetch_pc <= target;
            end
        end else begin
            unique case (state)
                FETCH: begin
                    imem_req <= 1'b1;
                    if (ack_v) begin
                        instr       <= imem_rdata;
                        pc          <= fetch_pc;
                        instr_valid <= 1'b1;
                        fetch_pc    <= fetch_pc + XLEN'(4);
                        state       <= FULL_FETCH;
                    end
                end
                FULL_FETCH: begin
                    if (take && ack_v) begin
                        instr    <= imem_rdata;
                        pc       <= fetch_pc;
                        fetch_pc <= fetch_pc + XLEN'(4);
                    end else if (take) begin
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                    end else if (ack_v) begin
                        pb       <= imem_rdata;
                        pb_pc    <= fetch_pc;
                        fetch_pc <= fetch_pc + XLEN'(4);
                        imem_req <= 1'b0;
                        state    <= FULL_HOLD;
                    end
                end
                FULL_HOLD: begin
                    if (take) begin
                        instr    <= pb;
                        pc       <= pb_pc;
                        imem_req <= 1'b1;
                        state    <= FULL_FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: a two-entry fetched-word queue model
// plus directed scenarios for stall, redirect, misalignment and PC wrap.
module tb_instr_fetch;
    import rv_fetch_pkg::*;

    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        imem_req, imem_ack, instr_valid, consume, redirect, misalign_err;
    logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4, redirect_target;
    logic [6:0]  op, funct7;
    logic [2:0]  funct3;

    logic        imem_req_w, imem_ack_w, instr_valid_w, misalign_err_w;
    logic [31:0] imem_addr_w, imem_rdata_w, instr_w, pc_w, pc_plus4_w;
    logic [6:0]  op_w, funct7_w;
    logic [2:0]  funct3_w;

    instr_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
        .op(op), .funct3(funct3), .funct7(funct7),
        .consume(consume), .redirect(redirect), .redirect_target(redirect_target),
        .misalign_err(misalign_err)
    );

    instr_fetch #(.XLEN(32), .RESET_PC(WRAP_PC)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_ack(imem_ack_w), .imem_rdata(imem_rdata_w),
        .instr_valid(instr_valid_w), .instr(instr_w), .pc(pc_w), .pc_plus4(pc_plus4_w),
        .op(op_w), .funct3(funct3_w), .funct7(funct7_w),
        .consume(1'b1), .redirect(1'b0), .redirect_target(32'h0),
        .misalign_err(misalign_err_w)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          lat      = 0;
    int          wait_cnt = 0;
    int          acks_seen = 0;
    bit          rand_lat = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_fetch;
    bit          discard;
    bit          exp_mis;
    logic        last_req, last_ack;
    logic [31:0] last_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_fetch = 32'h0;
        discard   = 1'b0;
        exp_mis   = 1'b0;
        wait_cnt  = 0;
        last_req  = 1'b0;
        last_ack  = 1'b0;
        last_addr = 32'h0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        consume = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0; imem_ack_w = 1'b0; imem_rdata_w = 32'h0;
        #1;
        check_eq("rst_req", 32'(imem_req), 32'h0);
        check_eq("rst_valid", 32'(instr_valid), 32'h0);
        check_eq("rst_instr", instr, 32'h0000_0013);
        check_eq("rst_op", 32'(op), 32'h13);
        check_eq("rst_funct3", 32'(funct3), 32'h0);
        check_eq("rst_funct7", 32'(funct7), 32'h0);
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_pc_plus4", pc_plus4, 32'h4);
        check_eq("rst_misalign", 32'(misalign_err), 32'h0);
        check_eq("rst_addr", imem_addr, 32'h0);
        check_eq("rst_wrap_pc", pc_w, WRAP_PC);
        check_eq("rst_wrap_pc_plus4", pc_plus4_w, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    // Check one cycle against the queue model, answer memory, drive the core
    // inputs, advance the model, then move to just after the next edge.
    task automatic run_cycle(input logic c, input logic r, input logic [31:0] t);
        logic        ack;
        logic        redir;
        logic [31:0] w;
        if (last_req && !last_ack) begin
            check_eq("req_held", 32'(imem_req), 32'h1);
            check_eq("addr_stable", imem_addr, last_addr);
        end
        check_eq("valid", 32'(instr_valid), 32'(exp_q.size() > 0));
        check_eq("req", 32'(imem_req), 32'(exp_q.size() < 2));
        check_eq("misalign", 32'(misalign_err), 32'(exp_mis));
        if (imem_req && !discard) check_eq("fetch_addr", imem_addr, exp_fetch);
        if (exp_q.size() > 0) begin
            w = mem_word(exp_q[0]);
            check_eq("pc", pc, exp_q[0]);
            check_eq("instr", instr, w);
            check_eq("pc_plus4", pc_plus4, exp_q[0] + 32'd4);
            check_eq("op", 32'(op), 32'(w[6:0]));
            check_eq("funct3", 32'(funct3), 32'(w[14:12]));
            check_eq("funct7", 32'(funct7), 32'(w[31:25]));
        end

        ack        = imem_req && (wait_cnt >= lat);
        imem_ack   = ack;
        imem_rdata = ack ? mem_word(imem_addr) : $urandom;
        consume    = c;
        redirect   = r;
        redirect_target = t;
        imem_ack_w   = imem_req_w;
        imem_rdata_w = mem_word(imem_addr_w);

        redir = c && r && (exp_q.size() > 0);
        if (c && exp_q.size() > 0) void'(exp_q.pop_front());
        if (ack) begin
            if (discard) discard = 1'b0;
            else if (!redir) begin
                exp_q.push_back(imem_addr);
                exp_fetch = imem_addr + 32'd4;
            end
        end
        if (redir) begin
            exp_q.delete();
            exp_fetch = {t[31:2], 2'b00};
            if (t[1:0] != 2'b00) exp_mis = 1'b1;
            if (imem_req && !ack) discard = 1'b1;
        end

        if (imem_req && !ack) wait_cnt++;
        else wait_cnt = 0;
        if (ack) begin
            acks_seen++;
            if (rand_lat) lat = $urandom_range(0, 3);
        end
        last_req  = imem_req;
        last_ack  = ack;
        last_addr = imem_addr;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int limit);
        for (int i = 0; i < limit && !instr_valid; i++) run_cycle(1'b0, 1'b0, 32'h0);
        check_eq("valid_within_bound", 32'(instr_valid), 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        c, r;
        logic [31:0] t;
        int          idle;
        rst = 1'b1;
        #2;

        // Zero-wait streaming, plus the wrap instance
        apply_reset();
        lat = 0;
        check_eq("first_req", 32'(imem_req), 32'h1);
        check_eq("first_addr", imem_addr, 32'h0);
        check_eq("wrap_addr0", imem_addr_w, WRAP_PC);
        run_cycle(1'b1, 1'b0, 32'h0);
        check_eq("wrap_addr1", imem_addr_w, 32'h0);
        check_eq("wrap_pc", pc_w, WRAP_PC);
        check_eq("wrap_pc_plus4", pc_plus4_w, 32'h0);
        for (int k = 0; k < 4; k++) begin
            check_eq("seq_valid", 32'(instr_valid), 32'h1);
            check_eq("seq_pc", pc, 32'(k * 4));
            run_cycle(1'b1, 1'b0, 32'h0);
        end

        // Stall: one more word lands in PB, then requests stop
        apply_reset();
        run_cycle(1'b0, 1'b0, 32'h0);
        run_cycle(1'b1, 1'b0, 32'h0);
        check_eq("stall_pc", pc, 32'h4);
        acks_seen = 0;
        repeat (3) run_cycle(1'b0, 1'b0, 32'h0);
        check_eq("stall_acks", 32'(acks_seen), 32'h1);
        check_eq("stall_req", 32'(imem_req), 32'h0);
        run_cycle(1'b1, 1'b0, 32'h0);
        check_eq("pb_valid", 32'(instr_valid), 32'h1);
        check_eq("pb_pc", pc, 32'h8);

        // Redirect while the request for 0x8 is still waiting
        apply_reset();
        lat = 0;
        run_cycle(1'b0, 1'b0, 32'h0);
        run_cycle(1'b1, 1'b0, 32'h0);
        lat = 3;
        check_eq("pend_addr", imem_addr, 32'h8);
        run_cycle(1'b1, 1'b1, 32'h100);
        repeat (3) begin
            check_eq("drop_addr", imem_addr, 32'h8);
            run_cycle(1'b0, 1'b0, 32'h0);
        end
        check_eq("redir_addr", imem_addr, 32'h100);
        wait_valid(12);
        check_eq("redir_pc", pc, 32'h100);

        // Redirect coinciding with ack, then a misaligned target
        apply_reset();
        lat = 0;
        run_cycle(1'b0, 1'b0, 32'h0);
        run_cycle(1'b1, 1'b0, 32'h0);
        run_cycle(1'b1, 1'b1, 32'h100);
        check_eq("same_ack_addr", imem_addr, 32'h100);
        check_eq("same_ack_valid", 32'(instr_valid), 32'h0);
        wait_valid(4);
        check_eq("same_ack_pc", pc, 32'h100);
        run_cycle(1'b1, 1'b1, 32'h102);
        check_eq("mis_set", 32'(misalign_err), 32'h1);
        check_eq("mis_addr", imem_addr, 32'h100);
        repeat (5) run_cycle(1'b1, 1'b0, 32'h0);
        check_eq("mis_sticky", 32'(misalign_err), 32'h1);

        // consume/redirect while IR empty, redirect without consume
        apply_reset();
        lat = 3;
        run_cycle(1'b1, 1'b1, 32'h200);
        check_eq("ign_addr", imem_addr, 32'h0);
        check_eq("ign_valid", 32'(instr_valid), 32'h0);
        wait_valid(8);
        check_eq("ign_pc", pc, 32'h0);
        run_cycle(1'b0, 1'b1, 32'h300);
        check_eq("nocons_valid", 32'(instr_valid), 32'h1);
        check_eq("nocons_pc", pc, 32'h0);
        run_cycle(1'b1, 1'b0, 32'h0);
        wait_valid(8);
        check_eq("nocons_next_pc", pc, 32'h4);

        // Randomized traffic with a mid-run reset
        apply_reset();
        rand_lat = 1'b1;
        lat = $urandom_range(0, 3);
        idle = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) apply_reset();
            c = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 9) < 2);
            case ($urandom_range(0, 7))
                0:       t = $urandom;
                1:       t = 32'hFFFF_FFF0 | ($urandom & 32'hC);
                default: t = $urandom & 32'h0000_0FFC;
            endcase
            run_cycle(c, r, t);
            if (!instr_valid) idle++;
            else idle = 0;
            if (idle > 40) begin
                check_eq("liveness", 32'(instr_valid), 32'h1);
                idle = 0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
